// File: rtl/piano_pkg.sv
// Shared constants for the PS/2 piano keyboard: parser states, prefix bytes
// and the set-2 scan codes of the two tracked octaves.
package piano_pkg;

  localparam int KEYS_PER_OCT = 12;
  localparam int NUM_KEYS     = 2 * KEYS_PER_OCT;

  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E0 = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kt_state_e;

  // Element i is the scan code of semitone i (listed from key 23 down to key 0).
  localparam logic [NUM_KEYS-1:0][7:0] SCAN_CODES = {
    8'h3C, 8'h3D, 8'h35, 8'h36, 8'h2C, 8'h2E, 8'h2D, 8'h24, 8'h26, 8'h1D, 8'h1E, 8'h15,
    8'h3A, 8'h3B, 8'h31, 8'h33, 8'h32, 8'h34, 8'h2A, 8'h21, 8'h23, 8'h22, 8'h1B, 8'h1A
  };

endpackage

// File: rtl/key_tracker_if.sv
// Byte-stream / key-map bundle between a PS/2 byte source and key_tracker.
interface key_tracker_if #(
  parameter int OCTAVES = 2
);
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   panic;
  logic [12*OCTAVES-1:0]  keys;
  logic [4:0]             note;
  logic                   press;
  logic                   note_chg;

  modport master (output byte_valid, byte_data, panic,
                  input  keys, note, press, note_chg);
  modport slave  (input  byte_valid, byte_data, panic,
                  output keys, note, press, note_chg);
endinterface

// File: rtl/scan_to_key.sv
// Combinational set-2 scan code decoder: hit=1 and idx=semitone for mapped codes.
module scan_to_key
  import piano_pkg::*;
(
  input  logic [7:0] byte_data,
  output logic       hit,
  output logic [4:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (byte_data == SCAN_CODES[i]) begin
        hit = 1'b1;
        idx = 5'(i);
      end
    end
  end

endmodule

// File: rtl/key_tracker.sv
// PS/2 set-2 byte parser tracking held piano keys and a last-pressed note
// selection for a monophonic tone generator.
module key_tracker
  import piano_pkg::*;
#(
  parameter int OCTAVES = 2
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  panic,
  output logic [12*OCTAVES-1:0] keys,
  output logic [4:0]            note,
  output logic                  press,
  output logic                  note_chg
);

  localparam int NK = KEYS_PER_OCT * OCTAVES;

  kt_state_e       state_q, state_d;
  logic [NK-1:0]   keys_q, keys_d;
  logic [4:0]      note_q, note_d;
  logic            press_q, press_d;
  logic            note_chg_q, note_chg_d;

  logic            hit;
  logic [4:0]      idx;

  scan_to_key u_dec (
    .byte_data (byte_data),
    .hit       (hit),
    .idx       (idx)
  );

  function automatic logic [4:0] lowest_key(input logic [NK-1:0] k);
    lowest_key = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (k[i]) lowest_key = 5'(i);
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    keys_d     = keys_q;
    note_d     = note_q;
    press_d    = press_q;
    note_chg_d = 1'b0;

    if (panic) begin
      // Byte in the same cycle is dropped; note is kept for the next press.
      state_d    = ST_IDLE;
      keys_d     = '0;
      press_d    = 1'b0;
      note_chg_d = press_q;
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_data == SC_F0)      state_d = ST_BRK;
          else if (byte_data == SC_E0) state_d = ST_EXT;
          else if (hit && !keys_q[idx]) begin
            keys_d[idx] = 1'b1;
            note_d      = idx;
            press_d     = 1'b1;
            note_chg_d  = 1'b1;
          end
        end
        ST_EXT:  state_d = (byte_data == SC_F0) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK: begin
          state_d = ST_IDLE;
          if (hit && keys_q[idx]) begin
            keys_d[idx] = 1'b0;
            if (keys_d == '0) begin
              press_d    = 1'b0;
              note_chg_d = 1'b1;
            end else if (idx == note_q) begin
              note_d     = lowest_key(keys_d);
              note_chg_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      keys_q     <= '0;
      note_q     <= '0;
      press_q    <= 1'b0;
      note_chg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      keys_q     <= keys_d;
      note_q     <= note_d;
      press_q    <= press_d;
      note_chg_q <= note_chg_d;
    end
  end

  assign keys     = keys_q;
  assign note     = note_q;
  assign press    = press_q;
  assign note_chg = note_chg_q;

endmodule

// File: doc/key_tracker.md
KEY_TRACKER -- requirements
Module: key_tracker

Interface
REQ-001 The module SHALL have parameter OCTAVES, default 2, giving the number of tracked octaves; only the value 2 is supported.
REQ-002 The module SHALL have port mclk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port byte_valid, input, 1 bit: one-cycle strobe marking a received PS/2 byte.
REQ-005 The module SHALL have port byte_data, input, 8 bits: set-2 scan code byte, sampled when byte_valid=1.
REQ-006 The module SHALL have port panic, input, 1 bit: clears all held keys.
REQ-007 The module SHALL have port keys, output, 12*OCTAVES bits: held-key map, bit i = semitone i (bit 0 = lowest C).
REQ-008 The module SHALL have port note, output, 5 bits: index of the key currently selected for the tone generator.
REQ-009 The module SHALL have port press, output, 1 bit: 1 when any key is held.
REQ-010 The module SHALL have port note_chg, output, 1 bit: one-cycle pulse when note or press changes.

Function
REQ-011 The parser SHALL be a 4-state FSM: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-012 Transitions SHALL occur only on cycles with byte_valid=1, as follows: IDLE+F0->BRK; IDLE+E0->EXT; EXT+F0->EXT_BRK; any other byte in EXT->IDLE; any byte in BRK or EXT_BRK->IDLE.
REQ-013 The mapping SHALL be: Z,S,X,D,C,V,G,B,H,N,J,M (1A,1B,22,23,21,2A,34,32,33,31,3B,3A) -> keys 0..11; Q,2,W,3,E,R,5,T,6,Y,7,U (15,1E,1D,26,24,2D,2E,2C,36,35,3D,3C) -> keys 12..23.
REQ-014 A mapped byte received in IDLE (make) SHALL set the key's bit; a mapped byte received in BRK (break) SHALL clear it.
REQ-015 Extended-prefixed bytes, unmapped codes and protocol bytes (AA, FA, FE, EE, 00, FF) SHALL leave keys, note and press unchanged.
REQ-016 keys, note, press and state SHALL update on the edge that samples byte_valid=1, so results are visible the next cycle (latency 1).
REQ-017 On a make of a key not already held, note SHALL become that key (last-pressed priority).
REQ-018 A typematic repeat (make of an already-held key) SHALL change neither note nor note_chg.
REQ-019 On a break of the key currently in note, note SHALL become the lowest-index key still held.
REQ-020 If no key remains held after a break, press SHALL be 0 and note SHALL hold its last value.
REQ-021 A break of a key that is not held SHALL have no effect.
REQ-022 A break of a held key other than note SHALL clear only that key's bit.
REQ-023 press SHALL equal OR-reduce of keys at all times (registered together with keys).
REQ-024 note_chg SHALL be asserted for exactly the cycle in which updated note/press first appear.
REQ-025 panic SHALL clear keys, set press=0, return the FSM to IDLE and leave note unchanged.
REQ-026 When panic and byte_valid are asserted in the same cycle, panic SHALL win and the byte SHALL be dropped.
REQ-027 panic SHALL pulse note_chg only if press was 1.

Reset
REQ-028 On rst=1, the module SHALL set state=IDLE, keys=0, note=0, press=0 and note_chg=0 at the next edge.
REQ-029 rst SHALL override panic and byte_valid.
REQ-030 rst asserted mid-sequence (e.g. after F0) SHALL discard the pending prefix.

Structure
REQ-031 The shared package piano_pkg SHALL hold the FSM state encoding, prefix constants (F0, E0), the 24 scan-code constants and KEYS_PER_OCT=12.
REQ-032 Decoding SHALL be done by one combinational sub-module, scan_to_key (byte in -> hit flag + 5-bit index).
REQ-033 The lowest-held-key priority encoder SHALL be inside key_tracker.

Verification
REQ-034 Bench case: rst, then byte 1A -> next cycle keys=0x000001, note=0, press=1, note_chg pulse.
REQ-035 Bench case: make 1A, make 3C, break (F0 3C) -> note=23 then note=0, keys=0x000001, press=1.
REQ-036 Bench case: make 15 three times (typematic) -> keys=0x001000, note=12, note_chg pulses once.
REQ-037 Bench case: E0 1A, then F0 99, then AA -> keys, note and press unchanged; FSM back in IDLE.
REQ-038 Bench case: keys 0,5,23 held, panic with simultaneous byte_valid=1 (byte 22) -> keys=0, press=0, note=23, note_chg pulse.
REQ-039 Bench case: F0 then rst, then byte 1A -> treated as make: keys=0x000001.
